seg_scan_decoder: RTL and testbench

- Monitor-side counterpart of the multiplexed 7-segment scan driver.
- Samples the scanned SEG/AN bus, waits for each digit to settle, and decodes the segment pattern back into a hex nibble, decimal point and blank flag per digit.
- Drives a frame-complete pulse once all four digits have been captured.
- Used for loopback self-check of the display path and as a bench/board probe.

---
 rtl/seg_scan_decoder.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Monitor-side decoder for a multiplexed 7-segment scan bus: waits for each digit to settle,
// decodes it back to a hex nibble/dp/blank flag and pulses frame_done once all four are captured.
// Optional stale-bus timeout is enabled with the SCAN_TIMEOUT_EN macro.
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [7:0]  SEG,
  input  logic [3:0]  AN,
  output logic [15:0] HEXS,
  output logic [3:0]  point,
  output logic [3:0]  LES,
  output logic [3:0]  valid,
  output logic        frame_done,
  output logic        code_err,
`ifdef SCAN_TIMEOUT_EN
  output logic        stale,
`endif
  output logic [1:0]  state_dbg
);

  if (STABLE_CYC < 2 || STABLE_CYC > 255 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("seg_scan_decoder: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [7:0] STB = 8'(STABLE_CYC);
  localparam logic [6:0] HEX_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  state_t      state;
  logic [7:0]  count;
  logic [7:0]  seg_q;
  logic [3:0]  an_q;
  logic [11:0] prev;
  logic [3:0]  seen;

  logic       changed;
  logic       accept;
  logic       one_hot;
  logic [1:0] idx;
  logic [3:0] sel;
  logic       dec_ok;
  logic [3:0] dec_val;
  logic       blank;

  assign state_dbg = state;
  assign changed   = ({an_q, seg_q} != prev);
  // The sample that arrives while count already equals STABLE_CYC is the one that commits
  // the digit; a change in that same cycle wins and nothing is accepted.
  assign accept    = (state == SETTLE) && !changed && (count == STB);
  assign blank     = (seg_q[6:0] == 7'h7F);

  always_comb begin
    one_hot = 1'b1;
    idx     = 2'd0;
    case (an_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
    sel = 4'b0001 << idx;
  end

  always_comb begin
    dec_ok  = 1'b0;
    dec_val = 4'd0;
    for (int v = 0; v < 16; v++) begin
      if (seg_q[6:0] == HEX_TBL[v]) begin
        dec_ok  = 1'b1;
        dec_val = 4'(v);
      end
    end
  end

`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      count      <= 8'd0;
      seg_q      <= 8'hFF;
      an_q       <= 4'hF;
      prev       <= 12'hFFF;
      seen       <= 4'd0;
      HEXS       <= 16'd0;
      point      <= 4'd0;
      LES        <= 4'hF;
      valid      <= 4'd0;
      frame_done <= 1'b0;
      code_err   <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      tcnt       <= '0;
      stale      <= 1'b0;
`endif
    end else begin
      seg_q      <= SEG;
      an_q       <= AN;
      prev       <= {an_q, seg_q};
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (an_q != 4'hF) begin
            state <= SETTLE;
            count <= 8'd1;
          end
        end
        SETTLE: begin
          if (changed) begin
            if (an_q == 4'hF) state <= IDLE;
            count <= 8'd1;
          end else if (count == STB) begin
            state <= HOLD;
          end else begin
            count <= count + 8'd1;
          end
        end
        HOLD: begin
          if (changed) begin
            state <= (an_q == 4'hF) ? IDLE : SETTLE;
            count <= 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        if (one_hot) begin
          point[idx] <= ~seg_q[7];
          if (blank) begin
            LES[idx]   <= 1'b1;
            valid[idx] <= 1'b0;
          end else if (dec_ok) begin
            HEXS[{idx, 2'b00} +: 4] <= dec_val;
            LES[idx]   <= 1'b0;
            valid[idx] <= 1'b1;
          end else begin
            code_err   <= 1'b1;
            valid[idx] <= 1'b0;
          end
          if ((seen | sel) == 4'hF) begin
            frame_done <= 1'b1;
            seen       <= 4'd0;
          end else begin
            seen <= seen | sel;
          end
        end else begin
          code_err <= 1'b1;
        end
      end

`ifdef SCAN_TIMEOUT_EN
      if (accept) begin
        tcnt  <= '0;
        stale <= 1'b0;
      end else if (tcnt != TMAX) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == TMAX - 1'b1) begin
          valid <= 4'd0;
          seen  <= 4'd0;
          stale <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: phase-based stimulus with a reference model feeding an expected queue.
// Define SCAN_TIMEOUT_EN to also exercise the stale timeout.
module tb_seg_scan_decoder;

  localparam int STB = 16;
  localparam int TMO = 64;
  localparam int PH  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] hexs;
  logic [3:0]  point, les, valid;
  logic        frame_done, code_err;
  logic [1:0]  state_dbg;
`ifdef SCAN_TIMEOUT_EN
  logic        stale;
`endif

  seg_scan_decoder #(.STABLE_CYC(STB), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .RST(rst), .SEG(seg), .AN(an),
    .HEXS(hexs), .point(point), .LES(les), .valid(valid),
    .frame_done(frame_done), .code_err(code_err),
`ifdef SCAN_TIMEOUT_EN
    .stale(stale),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [28:0] exp_q[$];

  logic [15:0] m_hexs;
  logic [3:0]  m_point, m_les, m_valid, m_mask;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] pack_model();
    return {m_hexs, m_point, m_les, m_valid, m_err};
  endfunction

  function automatic logic [28:0] pack_dut();
    return {hexs, point, les, valid, code_err};
  endfunction

  // Reference decode of the active-low gfedcba hex font; returns {ok, nibble}.
  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    case (p)
      7'h40: return 5'h10;  7'h79: return 5'h11;  7'h24: return 5'h12;  7'h30: return 5'h13;
      7'h19: return 5'h14;  7'h12: return 5'h15;  7'h02: return 5'h16;  7'h78: return 5'h17;
      7'h00: return 5'h18;  7'h10: return 5'h19;  7'h08: return 5'h1A;  7'h03: return 5'h1B;
      7'h46: return 5'h1C;  7'h21: return 5'h1D;  7'h06: return 5'h1E;  7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_hexs = 16'd0; m_point = 4'd0; m_les = 4'hF; m_valid = 4'd0; m_mask = 4'd0; m_err = 1'b0;
  endtask

  task automatic model_accept(input logic [3:0] a, input logic [7:0] s, output logic pulse);
    int i;
    logic [4:0] d;
    pulse = 1'b0;
    i = -1;
    for (int k = 0; k < 4; k++) if (a == ~(4'b0001 << k)) i = k;
    if (i < 0) begin
      m_err = 1'b1;
    end else begin
      d = ref_decode(s[6:0]);
      m_point[i] = ~s[7];
      if (s[6:0] == 7'h7F) begin
        m_les[i] = 1'b1; m_valid[i] = 1'b0;
      end else if (d[4]) begin
        m_hexs[i*4 +: 4] = d[3:0]; m_les[i] = 1'b0; m_valid[i] = 1'b1;
      end else begin
        m_err = 1'b1; m_valid[i] = 1'b0;
      end
      m_mask[i] = 1'b1;
      if (m_mask == 4'hF) begin
        pulse = 1'b1; m_mask = 4'd0;
      end
    end
  endtask

  // Holds {an,seg} for ncyc cycles. An accept commits STB+2 cycles after the value is driven.
  task automatic run_phase(input string tag, input logic [3:0] a, input logic [7:0] s, input int ncyc);
    int pulses = 0;
    int pulse_at = -1;
    logic exp_pulse = 1'b0;
    an = a; seg = s;
    if (a != 4'hF && ncyc >= STB + 2) model_accept(a, s, exp_pulse);
    exp_q.push_back(pack_model());
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); @(negedge clk);
      if (frame_done) begin pulses++; pulse_at = k; end
    end
    check({tag, "_frames"}, 32'(pulses), {31'd0, exp_pulse});
    if (exp_pulse) check({tag, "_frame_cycle"}, 32'(pulse_at), 32'(STB + 2));
    check(tag, {3'd0, pack_dut()}, {3'd0, exp_q.pop_front()});
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.push_back(pack_model());
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check(tag, {3'd0, pack_dut()}, {3'd0, exp_q.pop_front()});
  endtask

  initial begin
    rst = 1'b1; an = 4'hF; seg = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    pulse_reset("reset");

    run_phase("idle100", 4'hF, 8'hFF, 100);

    run_phase("dig0", 4'b1110, 8'hC0, PH);
    run_phase("dig1", 4'b1101, 8'hF9, PH);
    run_phase("dig2", 4'b1011, 8'hA4, PH);
    run_phase("dig3", 4'b0111, 8'hB0, PH);
    check("frame_hexs", {16'd0, hexs}, 32'h3210);
    check("frame_valid", {28'd0, valid}, 32'hF);

    run_phase("glitch_pre", 4'b1011, 8'h08, STB - 1);
    run_phase("glitch_tog", 4'b1011, 8'h09, 3);
    run_phase("glitch_hold", 4'b1011, 8'h08, PH);

    run_phase("blank_ff", 4'b1101, 8'hFF, PH);
    run_phase("blank_dp", 4'b1101, 8'h7F, PH);

    run_phase("an_multi", 4'b1100, 8'hC0, PH);
    pulse_reset("reset_mid");

    run_phase("bad_code", 4'b1101, 8'hAA, PH);
    run_phase("err_sticky", 4'b1110, 8'hC0, PH);
    run_phase("err_idle", 4'hF, 8'hFF, PH);
    pulse_reset("reset_err");

`ifdef SCAN_TIMEOUT_EN
    begin
      int stale_at = -1;
      run_phase("to_dig0", 4'b1110, 8'h99, PH);
      run_phase("to_dig1", 4'b1101, 8'h92, PH);
      run_phase("to_dig2", 4'b1011, 8'h82, PH);
      run_phase("to_dig3", 4'b0111, 8'hF8, PH);
      check("to_stale_early", {31'd0, stale}, 32'd0);
      an = 4'hF; seg = 8'hFF;
      for (int k = 1; k <= 70; k++) begin
        @(posedge clk); @(negedge clk);
        if (stale && stale_at < 0) stale_at = k;
      end
      check("to_stale_cycle", 32'(stale_at), 32'(TMO - (PH - (STB + 2))));
      m_valid = 4'd0; m_mask = 4'd0;
      exp_q.push_back(pack_model());
      check("to_outputs", {3'd0, pack_dut()}, {3'd0, exp_q.pop_front()});
      check("to_stale", {31'd0, stale}, 32'd1);
      run_phase("to_recover", 4'b1110, 8'hC0, PH);
      check("to_stale_clear", {31'd0, stale}, 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
